ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Sequencer that sits directly upstream of the 8x8 RAM and owns its rw/addr/data_in pins.
- Turns the single-port 8-word x 8-bit RAM into a circular FIFO with a push port and a pop port.
- Arbitrates push/pop conflicts on the single port with a fair toggle and tracks occupancy.
- Consumes the RAM's data_out and returns popped words on a registered output.

Parameters:
- DATA_W, 8, word width; must equal RAM data width.
- ADDR_W, 3, RAM address width; depth = 2**ADDR_W = 8.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clr  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous FIFO clear.
- push  input  1  producer requests a write.
- push_data  input  DATA_W  word to write.
- push_ready  output  1  push accepted this cycle when push=1.
- pop_req  input  1  consumer requests a read.
- pop_ready  output  1  pop accepted this cycle when pop_req=1.
- pop_data  output  DATA_W  registered popped word.
- pop_valid  output  1  one-cycle pulse; pop_data is valid.
- full  output  1  count == 8.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  occupancy, 0..8.
- ram_rw  output  1  1 = write, 0 = read; to RAM rw.
- ram_addr  output  ADDR_W  to RAM addr.
- ram_din  output  DATA_W  to RAM data_in.
- ram_dout  input  DATA_W  from RAM data_out; combinational read of ram_addr while ram_rw=0.

Behaviour:
- Reset (clr=1, async): wr_ptr=0, rd_ptr=0, count=0, prio=WRITE, pop_data=0, pop_valid=0. Outputs: empty=1, full=0.
- Eligibility:
  - wr_ok = push & ~full & ~flush.
  - rd_ok = pop_req & ~empty & ~flush.
- Grant:
  - Only wr_ok → write.
  - Only rd_ok → read.
  - Both (conflict) → winner is prio; prio toggles at the clock edge after each conflict cycle only.
- push_ready = wr_ok & (~rd_ok | prio==WRITE).
- pop_ready = rd_ok & (~wr_ok | prio==READ).
- Both readies are combinational; never both 1 in the same cycle.
- Write cycle:
  - ram_rw=1, ram_addr=wr_ptr, ram_din=push_data; RAM stores at the edge.
  - wr_ptr+1, wrapping 7→0.
- Read cycle:
  - ram_rw=0, ram_addr=rd_ptr; ram_dout is captured into pop_data at the edge.
  - pop_valid=1 for exactly the next cycle; rd_ptr+1 with wrap.
  - Latency pop accept → pop_valid = 1 cycle.
- Idle cycle:
  - ram_rw=0, ram_addr=rd_ptr, ram_din=0.
  - pop_data holds, pop_valid=0.
- count: +1 on write, −1 on read. Never both in one cycle (single port), so no underflow or overflow.
- Full: push_ready=0; pushes stall with no data loss. Producer must hold push and push_data until accepted.
- Empty: pop_ready=0. A push to an empty FIFO is readable from the next cycle.
- Wrap-around: pointers are pure modulo-8. full and empty come from count, not from pointer compare.
- flush (sync):
  - Pointers and count go to 0 and pop_valid to 0; prio is unchanged.
  - No RAM write that cycle; RAM contents are not cleared.
- clr mid-operation: all state clears immediately. A write in flight that cycle is not guaranteed.

Decomposition:
- Package ram_fifo_pkg holds:
  - DATA_W=8, ADDR_W=3, DEPTH=8.
  - prio encoding PRIO_WRITE=0, PRIO_READ=1.
- Sub-module fifo_ptr: ADDR_W-bit wrapping counter with inc, sync flush and async clr. Instantiated twice, for wr_ptr and rd_ptr.
- count, arbitration and the output register stay in the top.

Test Plan:
- Reset then 8 pushes of 0x10..0x17 with pop_req=0:
  - Each push_ready=1 and ram_rw=1 with ram_addr 0..7.
  - After the 8th, full=1 and count=8.
  - A 9th push sees push_ready=0.
- From full, hold pop_req for 8 cycles → pop_valid pulses each following cycle with pop_data 0x10..0x17 in order; then empty=1 and pop_ready=0.
- Wrap: push 6, pop 6, push 0xA0..0xA4 → ram_addr 6,7,0,1,2; popped order 0xA0..0xA4.
- Conflict: with count=3, hold push=1 (0x55) and pop_req=1 for 4 cycles:
  - Grants alternate write, read, write, read, starting with write after reset.
  - count goes 4,3,4,3.
- flush asserted with count=5 and push=1 → push_ready=0 that cycle; next cycle count=0, empty=1, pop_valid=0.
- clr pulsed mid-sequence between edges → count=0 and pop_valid=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing and arbitration encoding for the RAM-backed FIFO sequencer.
// Every other file of this block imports it.
package ram_fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        PRIO_WRITE = 1'b0,
        PRIO_READ  = 1'b1
    } prio_e;

    // Winner of the next push/pop conflict once the current conflict is served.
    function automatic prio_e prio_toggle(input prio_e p);
        return (p == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Handshake bundle between the FIFO sequencer, its producer/consumer and the RAM pins.
// slave = the sequencer itself, master = the user side driving requests and modelling the RAM.
interface ram_fifo_ctrl_if;
    import ram_fifo_pkg::*;

    logic              flush;
    logic              push;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              pop_req;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              ram_rw;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  flush, push, push_data, pop_req, ram_dout,
        output push_ready, pop_ready, pop_data, pop_valid,
               full, empty, count, ram_rw, ram_addr, ram_din
    );

    modport master (
        output flush, push, push_data, pop_req, ram_dout,
        input  push_ready, pop_ready, pop_data, pop_valid,
               full, empty, count, ram_rw, ram_addr, ram_din
    );

endinterface

// File: rtl/ram_fifo_ctrl_ptr.sv
// Wrapping RAM address pointer with synchronous flush and asynchronous clear.
// Pure modulo-2**W; occupancy is tracked elsewhere, never by comparing pointers.
module fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         flush_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Circular FIFO sequencer over a single-port 8x8 RAM: one access per cycle,
// push/pop conflicts resolved by a priority bit that flips after each conflict.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    ram_fifo_ctrl_if.slave   bus
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic [ADDR_W:0]   count_q,     count_d;
    prio_e             prio_q,      prio_d;
    logic [DATA_W-1:0] pop_data_q,  pop_data_d;
    logic              pop_valid_q, pop_valid_d;

    logic full;
    logic empty;
    logic wr_ok;
    logic rd_ok;
    logic grant_wr;
    logic grant_rd;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // flush blocks both requests, so a flush cycle is never a conflict and prio holds.
    assign wr_ok    = bus.push    & ~full  & ~bus.flush;
    assign rd_ok    = bus.pop_req & ~empty & ~bus.flush;
    assign grant_wr = wr_ok & (~rd_ok | (prio_q == PRIO_WRITE));
    assign grant_rd = rd_ok & (~wr_ok | (prio_q == PRIO_READ));

    fifo_ptr #(.W(ADDR_W)) u_wr_ptr (
        .clk     (clk),
        .clr     (clr),
        .flush_i (bus.flush),
        .inc_i   (grant_wr),
        .ptr_o   (wr_ptr)
    );

    fifo_ptr #(.W(ADDR_W)) u_rd_ptr (
        .clk     (clk),
        .clr     (clr),
        .flush_i (bus.flush),
        .inc_i   (grant_rd),
        .ptr_o   (rd_ptr)
    );

    always_comb begin
        count_d     = count_q;
        prio_d      = prio_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = grant_rd;

        if (wr_ok && rd_ok) begin
            prio_d = prio_toggle(prio_q);
        end

        // Single port: at most one of the grants is set, so count never moves by two.
        if (bus.flush) begin
            count_d = '0;
        end else if (grant_wr) begin
            count_d = count_q + 1'b1;
        end else if (grant_rd) begin
            count_d = count_q - 1'b1;
        end

        if (grant_rd) begin
            pop_data_d = bus.ram_dout;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q     <= '0;
            prio_q      <= PRIO_WRITE;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            prio_q      <= prio_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
        end
    end

    // Idle cycles park the address on rd_ptr so the head word is already on ram_dout.
    assign bus.ram_rw     = grant_wr;
    assign bus.ram_addr   = grant_wr ? wr_ptr : rd_ptr;
    assign bus.ram_din    = grant_wr ? bus.push_data : '0;

    assign bus.push_ready = grant_wr;
    assign bus.pop_ready  = grant_rd;
    assign bus.pop_data   = pop_data_q;
    assign bus.pop_valid  = pop_valid_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 8x8 single-port RAM attached.
// Each scenario task drives vectors and compares against hand-computed values.
module tb_ram_fifo_ctrl;
    import ram_fifo_pkg::*;

    logic clk;
    logic clr;
    int   checks;
    int   failures;

    ram_fifo_ctrl_if bus ();

    ram_fifo_ctrl dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: synchronous write, combinational read of the presented address.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_rw) mem[bus.ram_addr] <= bus.ram_din;
    end
    assign bus.ram_dout = mem[bus.ram_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush     = 1'b0;
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.pop_req   = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", bus.full); end
        checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL reset_pop_valid got=%0b exp=0", bus.pop_valid); end
        checks++; if (bus.pop_data !== 8'h00) begin failures++; $display("FAIL reset_pop_data got=%02h exp=00", bus.pop_data); end
        $display("reset: count=%0d empty=%0b full=%0b", bus.count, bus.empty, bus.full);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            bus.push      = 1'b1;
            bus.push_data = 8'h10 + 8'(i);
            #1;
            checks++; if (bus.push_ready !== 1'b1) begin failures++; $display("FAIL fill_push_ready[%0d] got=%0b exp=1", i, bus.push_ready); end
            checks++; if (bus.ram_rw !== 1'b1) begin failures++; $display("FAIL fill_ram_rw[%0d] got=%0b exp=1", i, bus.ram_rw); end
            checks++; if (bus.ram_addr !== 3'(i)) begin failures++; $display("FAIL fill_ram_addr[%0d] got=%0d exp=%0d", i, bus.ram_addr, i); end
            $display("push data=%02h addr=%0d", bus.push_data, bus.ram_addr);
            step();
        end
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", bus.full); end
        checks++; if (bus.count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", bus.count); end
        bus.push_data = 8'h18;
        #1;
        checks++; if (bus.push_ready !== 1'b0) begin failures++; $display("FAIL fill_9th_push_ready got=%0b exp=0", bus.push_ready); end
        checks++; if (bus.ram_rw !== 1'b0) begin failures++; $display("FAIL fill_9th_ram_rw got=%0b exp=0", bus.ram_rw); end
        step();
        checks++; if (bus.count !== 4'd8) begin failures++; $display("FAIL fill_9th_count got=%0d exp=8", bus.count); end
        idle_inputs();
    endtask

    task automatic test_drain();
        bus.pop_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (bus.pop_ready !== 1'b1) begin failures++; $display("FAIL drain_pop_ready[%0d] got=%0b exp=1", i, bus.pop_ready); end
            step();
            checks++; if (bus.pop_valid !== 1'b1) begin failures++; $display("FAIL drain_pop_valid[%0d] got=%0b exp=1", i, bus.pop_valid); end
            checks++; if (bus.pop_data !== 8'h10 + 8'(i)) begin failures++; $display("FAIL drain_pop_data[%0d] got=%02h exp=%02h", i, bus.pop_data, 8'h10 + 8'(i)); end
            $display("pop data=%02h", bus.pop_data);
        end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", bus.empty); end
        checks++; if (bus.pop_ready !== 1'b0) begin failures++; $display("FAIL drain_pop_ready_empty got=%0b exp=0", bus.pop_ready); end
        step();
        checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL drain_no_pop_valid got=%0b exp=0", bus.pop_valid); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        logic [2:0] exp_addr [5];
        exp_addr = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
        // Advance both pointers to 6.
        for (int i = 0; i < 6; i++) begin
            bus.push = 1'b1; bus.push_data = 8'hE0 + 8'(i);
            step();
        end
        bus.push = 1'b0; bus.pop_req = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.pop_req = 1'b0;
        checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL wrap_pre_count got=%0d exp=0", bus.count); end
        for (int i = 0; i < 5; i++) begin
            bus.push = 1'b1; bus.push_data = 8'hA0 + 8'(i);
            #1;
            checks++; if (bus.ram_addr !== exp_addr[i]) begin failures++; $display("FAIL wrap_ram_addr[%0d] got=%0d exp=%0d", i, bus.ram_addr, exp_addr[i]); end
            $display("push data=%02h addr=%0d", bus.push_data, bus.ram_addr);
            step();
        end
        bus.push = 1'b0; bus.pop_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'hA0 + 8'(i)) begin
                failures++; $display("FAIL wrap_pop[%0d] got valid=%0b data=%02h exp valid=1 data=%02h", i, bus.pop_valid, bus.pop_data, 8'hA0 + 8'(i));
            end
            $display("pop data=%02h", bus.pop_data);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_conflict();
        logic [3:0] exp_count [4];
        logic [7:0] exp_pop [2];
        exp_count = '{4'd4, 4'd3, 4'd4, 4'd3};
        exp_pop   = '{8'h31, 8'h32};
        for (int i = 0; i < 3; i++) begin
            bus.push = 1'b1; bus.push_data = 8'h31 + 8'(i);
            step();
        end
        checks++; if (bus.count !== 4'd3) begin failures++; $display("FAIL conflict_pre_count got=%0d exp=3", bus.count); end
        bus.push = 1'b1; bus.push_data = 8'h55; bus.pop_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.push_ready !== ((i % 2) == 0) || bus.pop_ready !== ((i % 2) == 1)) begin
                failures++; $display("FAIL conflict_grant[%0d] got push_ready=%0b pop_ready=%0b exp push_ready=%0b pop_ready=%0b",
                                     i, bus.push_ready, bus.pop_ready, (i % 2) == 0, (i % 2) == 1);
            end
            $display("conflict cycle %0d push_ready=%0b pop_ready=%0b", i, bus.push_ready, bus.pop_ready);
            step();
            checks++; if (bus.count !== exp_count[i]) begin failures++; $display("FAIL conflict_count[%0d] got=%0d exp=%0d", i, bus.count, exp_count[i]); end
            if ((i % 2) == 1) begin
                checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== exp_pop[i/2]) begin
                    failures++; $display("FAIL conflict_pop[%0d] got valid=%0b data=%02h exp valid=1 data=%02h", i, bus.pop_valid, bus.pop_data, exp_pop[i/2]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        // Queue holds 0x33,0x55,0x55; three more pushes then one pop leave count=5.
        for (int i = 0; i < 3; i++) begin
            bus.push = 1'b1; bus.push_data = 8'h60 + 8'(i);
            step();
        end
        bus.push = 1'b0; bus.pop_req = 1'b1;
        step();
        checks++; if (bus.count !== 4'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", bus.count); end
        checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 8'h33) begin
            failures++; $display("FAIL flush_pre_pop got valid=%0b data=%02h exp valid=1 data=33", bus.pop_valid, bus.pop_data);
        end
        bus.flush = 1'b1; bus.push = 1'b1; bus.push_data = 8'h77; bus.pop_req = 1'b1;
        #1;
        checks++; if (bus.push_ready !== 1'b0) begin failures++; $display("FAIL flush_push_ready got=%0b exp=0", bus.push_ready); end
        checks++; if (bus.pop_ready !== 1'b0) begin failures++; $display("FAIL flush_pop_ready got=%0b exp=0", bus.pop_ready); end
        checks++; if (bus.ram_rw !== 1'b0) begin failures++; $display("FAIL flush_ram_rw got=%0b exp=0", bus.ram_rw); end
        step();
        idle_inputs();
        checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
            failures++; $display("FAIL flush_count got count=%0d empty=%0b exp count=0 empty=1", bus.count, bus.empty);
        end
        checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL flush_pop_valid got=%0b exp=0", bus.pop_valid); end
        $display("flush: count=%0d empty=%0b", bus.count, bus.empty);
    endtask

    task automatic test_clr_async();
        bus.push = 1'b1; bus.push_data = 8'h81;
        step();
        bus.push_data = 8'h82;
        step();
        bus.push = 1'b0; bus.pop_req = 1'b1;
        step();
        bus.pop_req = 1'b0;
        checks++; if (bus.pop_valid !== 1'b1 || bus.count !== 4'd1) begin
            failures++; $display("FAIL clr_pre got valid=%0b count=%0d exp valid=1 count=1", bus.pop_valid, bus.count);
        end
        #2;
        clr = 1'b1;
        #1;
        checks++; if (bus.count !== 4'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", bus.count); end
        checks++; if (bus.pop_valid !== 1'b0) begin failures++; $display("FAIL clr_pop_valid got=%0b exp=0", bus.pop_valid); end
        checks++; if (bus.pop_data !== 8'h00) begin failures++; $display("FAIL clr_pop_data got=%02h exp=00", bus.pop_data); end
        $display("clr: count=%0d pop_valid=%0b", bus.count, bus.pop_valid);
        #1;
        clr = 1'b0;
        step();
        bus.push = 1'b1; bus.push_data = 8'h90;
        #1;
        checks++; if (bus.ram_addr !== 3'd0 || bus.push_ready !== 1'b1) begin
            failures++; $display("FAIL clr_post_push got addr=%0d ready=%0b exp addr=0 ready=1", bus.ram_addr, bus.push_ready);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr      = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        @(posedge clk);
        #1;
        clr = 1'b0;
        step();
        test_fill();
        test_drain();
        test_wrap();
        test_conflict();
        test_flush();
        test_clr_async();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
